// File: rtl/register_bank_pkg.sv
// Shared defaults and dump-sequencer state encoding for the MIPS ID-stage register bank.
package register_bank_pkg;

  localparam int unsigned DEFAULT_REGISTERS_BANK_SIZE = 32;
  localparam int unsigned DEFAULT_REGISTERS_SIZE      = 32;

  typedef enum logic [1:0] {
    REG_DUMP_IDLE = 2'd0,
    REG_DUMP_SEND = 2'd1,
    REG_DUMP_DONE = 2'd2
  } dump_state_e;

endpackage

// File: rtl/register_bank_dump_ctrl.sv
// Snapshot dump sequencer: walks every register index under a valid/ready handshake.
module register_bank_dump_ctrl
  import register_bank_pkg::*;
#(
  parameter int unsigned DEPTH     = DEFAULT_REGISTERS_BANK_SIZE,
  parameter int unsigned ADDR_SIZE = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 dump_start,
  input  logic                 dump_ready,
  output logic [ADDR_SIZE-1:0] index,
  output logic                 valid,
  output logic                 done,
  output logic                 busy
);

  localparam logic [ADDR_SIZE-1:0] LAST_IDX = ADDR_SIZE'(DEPTH - 1);

  dump_state_e          state_q, state_d;
  logic [ADDR_SIZE-1:0] index_q, index_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= REG_DUMP_IDLE;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
    end
  end

  // Flush overrides every transition, including an in-flight dump.
  always_comb begin
    state_d = state_q;
    index_d = index_q;
    unique case (state_q)
      REG_DUMP_IDLE: begin
        if (dump_start) begin
          state_d = REG_DUMP_SEND;
          index_d = '0;
        end
      end
      REG_DUMP_SEND: begin
        if (dump_ready) begin
          if (index_q == LAST_IDX) state_d = REG_DUMP_DONE;
          else                     index_d = index_q + ADDR_SIZE'(1);
        end
      end
      REG_DUMP_DONE: begin
        state_d = REG_DUMP_IDLE;
        index_d = '0;
      end
      default: begin
        state_d = REG_DUMP_IDLE;
        index_d = '0;
      end
    endcase
    if (flush) begin
      state_d = REG_DUMP_IDLE;
      index_d = '0;
    end
  end

  assign index = index_q;
  assign valid = (state_q == REG_DUMP_SEND);
  assign done  = (state_q == REG_DUMP_DONE);
  assign busy  = (state_q != REG_DUMP_IDLE);

endmodule

// File: rtl/register_bank.sv
// MIPS ID-stage register file with r0 hardwired to zero and a snapshot dump port.
// Optional same-cycle write-through bypass: define REGISTER_BANK_BYPASS_EN.
module register_bank
  import register_bank_pkg::*;
#(
  parameter int unsigned REGISTERS_BANK_SIZE = DEFAULT_REGISTERS_BANK_SIZE,
  parameter int unsigned REGISTERS_SIZE      = DEFAULT_REGISTERS_SIZE,
  parameter int unsigned ADDR_SIZE           = $clog2(REGISTERS_BANK_SIZE)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      flush,
  input  logic                      write_enable,
  input  logic [ADDR_SIZE-1:0]      addr_wr,
  input  logic [REGISTERS_SIZE-1:0] bus_wr,
  input  logic [ADDR_SIZE-1:0]      addr_a,
  input  logic [ADDR_SIZE-1:0]      addr_b,
  output logic [REGISTERS_SIZE-1:0] bus_a,
  output logic [REGISTERS_SIZE-1:0] bus_b,
  input  logic                      dump_start,
  input  logic                      dump_ready,
  output logic                      dump_valid,
  output logic [ADDR_SIZE-1:0]      dump_addr,
  output logic [REGISTERS_SIZE-1:0] dump_data,
  output logic                      dump_done,
  output logic                      busy
);

  logic [REGISTERS_SIZE-1:0] regs_q [REGISTERS_BANK_SIZE];
  logic [REGISTERS_SIZE-1:0] regs_d [REGISTERS_BANK_SIZE];
  logic [ADDR_SIZE-1:0]      dump_idx;
  logic                      wr_accept_c;

  register_bank_dump_ctrl #(
    .DEPTH     (REGISTERS_BANK_SIZE),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_dump_ctrl (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .dump_start (dump_start),
    .dump_ready (dump_ready),
    .index      (dump_idx),
    .valid      (dump_valid),
    .done       (dump_done),
    .busy       (busy)
  );

  // Writes are frozen during a dump so the host sees a consistent snapshot.
  assign wr_accept_c = write_enable && enable && !busy && !flush && (addr_wr != '0);

  always_comb begin
    regs_d = regs_q;
    if (flush) begin
      for (int i = 0; i < int'(REGISTERS_BANK_SIZE); i++) regs_d[i] = '0;
    end else if (wr_accept_c) begin
      regs_d[addr_wr] = bus_wr;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(REGISTERS_BANK_SIZE); i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(REGISTERS_BANK_SIZE); i++) regs_q[i] <= regs_d[i];
    end
  end

  // r0 is never written, so its storage reads as zero without extra muxing.
`ifdef REGISTER_BANK_BYPASS_EN
  assign bus_a = (wr_accept_c && (addr_wr == addr_a)) ? bus_wr : regs_q[addr_a];
  assign bus_b = (wr_accept_c && (addr_wr == addr_b)) ? bus_wr : regs_q[addr_b];
`else
  assign bus_a = regs_q[addr_a];
  assign bus_b = regs_q[addr_b];
`endif

  assign dump_addr = dump_valid ? dump_idx         : '0;
  assign dump_data = dump_valid ? regs_q[dump_idx] : '0;

endmodule

// File: tb/tb_register_bank.sv
// Scoreboard bench for register_bank: write/read, r0, bypass, dump with stall, flush and reset aborts.
module tb_register_bank;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        flush;
  logic        write_enable;
  logic [4:0]  addr_wr;
  logic [31:0] bus_wr;
  logic [4:0]  addr_a;
  logic [4:0]  addr_b;
  logic [31:0] bus_a;
  logic [31:0] bus_b;
  logic        dump_start;
  logic        dump_ready;
  logic        dump_valid;
  logic [4:0]  dump_addr;
  logic [31:0] dump_data;
  logic        dump_done;
  logic        busy;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] mdl [32];
  exp_t        sb [$];

  register_bank dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .flush        (flush),
    .write_enable (write_enable),
    .addr_wr      (addr_wr),
    .bus_wr       (bus_wr),
    .addr_a       (addr_a),
    .addr_b       (addr_b),
    .bus_a        (bus_a),
    .bus_b        (bus_b),
    .dump_start   (dump_start),
    .dump_ready   (dump_ready),
    .dump_valid   (dump_valid),
    .dump_addr    (dump_addr),
    .dump_data    (dump_data),
    .dump_done    (dump_done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    write_enable = 1'b1;
    addr_wr      = 5'(a);
    bus_wr       = d;
    tick();
    write_enable = 1'b0;
    if (enable && a != 0) mdl[a] = d;
  endtask

  task automatic read_all(input string tag);
    for (int i = 0; i < 32; i++) begin
      addr_a = 5'(i);
      addr_b = 5'(31 - i);
      #1;
      check({tag, "_a"}, bus_a, mdl[i]);
      check({tag, "_b"}, bus_b, mdl[31 - i]);
    end
  endtask

  // Runs one dump; expected words come from the bench model, popped on each accepted handshake.
  task automatic run_dump(input int stall_lo, input int stall_hi, input int flush_word,
                          input int wr3_k, output int done_cnt, output int done_k);
    exp_t        e;
    logic [4:0]  sa;
    logic [31:0] sd;
    logic        stalled;
    done_cnt = 0;
    done_k   = -1;
    stalled  = 1'b0;
    sa       = '0;
    sd       = '0;
    for (int i = 0; i < 32; i++) begin
      e.addr = 5'(i);
      e.data = mdl[i];
      sb.push_back(e);
    end
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      dump_ready   = !(k >= stall_lo && k <= stall_hi);
      write_enable = (k == wr3_k);
      addr_wr      = 5'd3;
      bus_wr       = 32'hBAD0_BAD0;
      flush        = dump_valid && (int'(dump_addr) == flush_word);
      #1;
      if (stalled) begin
        check("stall_addr", 32'(dump_addr), 32'(sa));
        check("stall_data", dump_data, sd);
      end
      if (dump_valid && dump_ready && !flush) begin
        if (sb.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          check("dump_addr", 32'(dump_addr), 32'(e.addr));
          check("dump_data", dump_data, e.data);
        end
      end
      if (dump_done) begin
        done_cnt++;
        done_k = k;
      end
      stalled = dump_valid && !dump_ready;
      sa      = dump_addr;
      sd      = dump_data;
      if (flush) begin
        tick();
        flush = 1'b0;
        sb.delete();
        break;
      end
      tick();
      if (!busy) break;
    end
    write_enable = 1'b0;
    dump_ready   = 1'b1;
    flush        = 1'b0;
    check("dump_busy_end", 32'(busy), 32'd0);
    check("sb_left", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int dc;
    int dk;
    bit hit;
    reset_n      = 1'b0;
    enable       = 1'b1;
    flush        = 1'b0;
    write_enable = 1'b0;
    addr_wr      = '0;
    bus_wr       = '0;
    addr_a       = 5'd5;
    addr_b       = 5'd0;
    dump_start   = 1'b0;
    dump_ready   = 1'b1;
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    tick();
    tick();

    check("rst_bus_a", bus_a, 32'd0);
    check("rst_valid", 32'(dump_valid), 32'd0);
    check("rst_done", 32'(dump_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_daddr", 32'(dump_addr), 32'd0);
    check("rst_ddata", dump_data, 32'd0);
    reset_n = 1'b1;
    tick();

    // Write r5, visible next cycle; r0 reads zero.
    wr(5, 32'hDEAD_BEEF);
    check("r5_after_wr", bus_a, 32'hDEAD_BEEF);
    check("r0_b", bus_b, 32'd0);

    // Write to r0 is discarded.
    addr_a = 5'd0;
    wr(0, 32'h0000_1234);
    check("r0_after_wr", bus_a, 32'd0);
    read_all("r0_wr_side");

    // Same-cycle visibility of a write to r7.
    wr(7, 32'h0000_0077);
    addr_a       = 5'd7;
    write_enable = 1'b1;
    addr_wr      = 5'd7;
    bus_wr       = 32'hA5A5_A5A5;
    #1;
`ifdef REGISTER_BANK_BYPASS_EN
    check("bypass_same_cyc", bus_a, 32'hA5A5_A5A5);
`else
    check("nobypass_same_cyc", bus_a, 32'h0000_0077);
`endif
    tick();
    write_enable = 1'b0;
    mdl[7] = 32'hA5A5_A5A5;
    check("r7_next_cyc", bus_a, 32'hA5A5_A5A5);

    // Preload and check enable=0 suppresses writes.
    for (int i = 1; i < 32; i++) wr(i, 32'(i + 32'h100));
    enable = 1'b0;
    wr(9, 32'hFFFF_FFFF);
    enable = 1'b1;
    read_all("preload");

    // Full dump, ready held high: done exactly once at t+33.
    addr_a = 5'd1;
    run_dump(0, -1, -1, -1, dc, dk);
    check("done_cnt", 32'(dc), 32'd1);
    check("done_cycle", 32'(dk), 32'd33);

    // Backpressure window plus a blocked write to r3.
    run_dump(6, 8, -1, 4, dc, dk);
    check("bp_done_cnt", 32'(dc), 32'd1);
    check("bp_done_cycle", 32'(dk), 32'd36);
    addr_a = 5'd3;
    #1;
    check("r3_unchanged", bus_a, 32'h0000_0103);

    // Flush at word 10: abort with no done, all registers cleared.
    run_dump(0, -1, 10, -1, dc, dk);
    check("flush_done_cnt", 32'(dc), 32'd0);
    dc = 0;
    for (int k = 0; k < 5; k++) begin
      if (dump_done || dump_valid) dc++;
      tick();
    end
    check("flush_quiet", 32'(dc), 32'd0);
    for (int i = 0; i < 32; i++) mdl[i] = '0;
    read_all("flush");

    // Reset asserted at word 4: asynchronous clear of all outputs.
    wr(4, 32'h0000_0044);
    addr_a     = 5'd4;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    hit = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (dump_valid && dump_addr == 5'd4) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
    check("rst_mid_reached", 32'(hit), 32'd1);
    check("rst_mid_pre_data", dump_data, 32'h0000_0044);
    #2;
    reset_n = 1'b0;
    #1;
    check("rstmid_valid", 32'(dump_valid), 32'd0);
    check("rstmid_addr", 32'(dump_addr), 32'd0);
    check("rstmid_data", dump_data, 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    check("rstmid_done", 32'(dump_done), 32'd0);
    check("rstmid_bus_a", bus_a, 32'd0);
    tick();
    reset_n = 1'b1;
    dc = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (dump_done || busy) dc++;
    end
    check("rstmid_no_done", 32'(dc), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
